board_io_ctrl: RTL and testbench
================================

BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

Interface
REQ-001 SHALL have parameter NUM_OF_ANODES, default 4, number of 7-segment digits (1..8).
REQ-002 SHALL have parameter NUM_USED_SWITCHES, default 4, number of debounced switch inputs.
REQ-003 SHALL have parameter NUM_USED_LEDS, default 4, number of LED outputs.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 125000, stable-time in clk cycles (10 ms at 12.5 MHz), minimum 2.
REQ-005 SHALL have parameter SCAN_CYCLES, default 12500, clk cycles per digit slot, minimum 4.
REQ-006 SHALL have parameter BLANK_CYCLES, default 250, all-anodes-off cycles at the start of each slot, less than SCAN_CYCLES.
REQ-007 SHALL have parameter HEARTBEAT_BIT, default 25, heartbeat counter bit index.
REQ-008 SHALL have ports, in this order:
  clk  in  1  system clock (clk_system domain); one clock only
  reset  in  1  synchronous, active-high reset
  sw_i  in  NUM_USED_SWITCHES  raw asynchronous switch levels
  sw_o  out  NUM_USED_SWITCHES  debounced switch levels
  sw_rise_o  out  NUM_USED_SWITCHES  one-cycle pulse on debounced 0->1
  led_i  in  NUM_USED_LEDS  LED requests from fabric
  led_o  out  NUM_USED_LEDS  registered LED drive
  display_i  in  4*NUM_OF_ANODES  hex nibbles; nibble k shown on digit k
  display_en_i  in  1  1 = display scanning on, 0 = all anodes off
  an  out  NUM_OF_ANODES  anodes, active-low
  seg  out  7  segments {g..a}, active-low
  dp  out  1  decimal point, active-low, held 1 (off)
  heartbeat  out  1  free-running blink

Function
REQ-009 Each sw_i bit SHALL pass through a 2-flop synchroniser before debouncing.
REQ-010 Per switch: counter clears whenever synchronised level equals sw_o; otherwise increments; on reaching DEBOUNCE_CYCLES-1 SHALL update sw_o and clear the counter.
REQ-011 Latency: a clean sw_i edge held stable SHALL appear on sw_o exactly DEBOUNCE_CYCLES+2 cycles later.
REQ-012 A glitch shorter than DEBOUNCE_CYCLES cycles (after sync) SHALL NOT change sw_o; counter restarts from 0 on return.
REQ-013 sw_rise_o[i] SHALL be 1 for exactly the cycle in which sw_o[i] first reads 1; no pulse on 1->0.
REQ-014 led_o SHALL equal led_i delayed by one cycle.
REQ-015 Scan prescaler SHALL count 0..SCAN_CYCLES-1 and wrap; at wrap, digit index SHALL increment, wrapping NUM_OF_ANODES-1 -> 0.
REQ-016 When prescaler < BLANK_CYCLES, an SHALL be all ones; otherwise an SHALL be one-hot-low at digit index.
REQ-017 seg SHALL be the registered active-low hex decode (0-F) of nibble display_i[4*idx+3:4*idx], updated in the same cycle as an.
REQ-018 display_en_i=0 SHALL force an all ones and seg all ones on the next cycle; prescaler and index keep running.
REQ-019 display_i changes SHALL take effect at the next registered update (1-cycle latency), no shadowing.
REQ-020 Heartbeat counter SHALL be HEARTBEAT_BIT+1 bits, increment every cycle, wrap silently; heartbeat = its top bit.
REQ-021 NUM_OF_ANODES=1 SHALL be legal: index fixed at 0, blanking still applied.

Reset
REQ-022 While reset=1 at a clk edge: sw_o, sw_rise_o, led_o, synchronisers, debounce counters, prescaler, index, heartbeat counter SHALL clear to 0; an, seg, dp SHALL be all ones.
REQ-023 Reset mid-debounce SHALL discard progress; post-reset timing restarts per REQ-011 measured from reset deassertion.

Structure
REQ-024 Package board_io_pkg SHALL hold the 16-entry hex-to-segment constant table and the SEG_OFF constant (7'h7F).
REQ-025 Sub-module switch_debounce (synchroniser + counter + rise detect, one bit, DEBOUNCE_CYCLES parameter) SHALL be instantiated NUM_USED_SWITCHES times via generate.

Verification (DEBOUNCE_CYCLES=4, SCAN_CYCLES=8, BLANK_CYCLES=2, NUM_OF_ANODES=4, HEARTBEAT_BIT=3)
REQ-026 sw_i[0] 0->1 held -> sw_o[0]=1 and sw_rise_o[0]=1 exactly 6 cycles later; sw_rise_o[0]=0 the cycle after.
REQ-027 sw_i[1] high for 3 cycles then low -> sw_o[1] stays 0, sw_rise_o[1] never pulses.
REQ-028 display_i=16'h1234, display_en_i=1 -> per 8-cycle slot: 2 cycles an=4'b1111, 6 cycles an one-hot-low; digit 0 seg=7'b0011001 ("4"), digit 1 seg=7'b0110000 ("3"), sequence 0,1,2,3,0.
REQ-029 display_en_i dropped mid-slot -> an=4'b1111, seg=7'h7F next cycle; re-raise resumes at current index.
REQ-030 reset asserted 2 cycles into a debounce and in mid-scan -> all outputs at REQ-022 values next edge; heartbeat toggles every 8 cycles after release.

Source files
------------

// File: rtl/board_io_pkg.sv
// Shared constants for the board I/O block: active-low 7-segment patterns {g..a}.
package board_io_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/board_io_ctrl_switch_debounce.sv
// One-bit switch conditioner: 2-flop synchroniser, stable-time debounce counter,
// and a single-cycle pulse on the debounced 0->1 transition.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 125000
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             rise_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= sw;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                // The new level has now been seen for DEBOUNCE_CYCLES edges in a row.
                level_reg <= sync2_reg;
                rise_reg  <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O controller: debounced switches, registered LEDs, multiplexed
// 7-segment display with per-slot blanking, and a heartbeat blinker.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int NUM_OF_ANODES     = 4,
    parameter int NUM_USED_SWITCHES = 4,
    parameter int NUM_USED_LEDS     = 4,
    parameter int DEBOUNCE_CYCLES   = 125000,
    parameter int SCAN_CYCLES       = 12500,
    parameter int BLANK_CYCLES      = 250,
    parameter int HEARTBEAT_BIT     = 25
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_USED_SWITCHES-1:0] sw_i,
    output logic [NUM_USED_SWITCHES-1:0] sw_o,
    output logic [NUM_USED_SWITCHES-1:0] sw_rise_o,
    input  logic [NUM_USED_LEDS-1:0]     led_i,
    output logic [NUM_USED_LEDS-1:0]     led_o,
    input  logic [4*NUM_OF_ANODES-1:0]   display_i,
    input  logic                         display_en_i,
    output logic [NUM_OF_ANODES-1:0]     an,
    output logic [6:0]                   seg,
    output logic                         dp,
    output logic                         heartbeat
);

    localparam int PRE_W = $clog2(SCAN_CYCLES);
    localparam int IDX_W = (NUM_OF_ANODES > 1) ? $clog2(NUM_OF_ANODES) : 1;
    localparam logic [NUM_OF_ANODES-1:0] AN_ONE = NUM_OF_ANODES'(1);

    genvar gi;

    generate
        for (gi = 0; gi < NUM_USED_SWITCHES; gi++) begin : g_sw
            switch_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .reset(reset),
                .sw   (sw_i[gi]),
                .level(sw_o[gi]),
                .rise (sw_rise_o[gi])
            );
        end
    endgenerate

    logic [3:0] nibbles [NUM_OF_ANODES];

    generate
        for (gi = 0; gi < NUM_OF_ANODES; gi++) begin : g_nib
            assign nibbles[gi] = display_i[4*gi +: 4];
        end
    endgenerate

    logic [NUM_USED_LEDS-1:0] led_reg;
    logic [PRE_W-1:0]         presc_reg;
    logic [IDX_W-1:0]         idx_reg;
    logic [NUM_OF_ANODES-1:0] an_reg;
    logic [NUM_OF_ANODES-1:0] an_next;
    logic [6:0]               seg_reg;
    logic [6:0]               seg_next;
    logic [HEARTBEAT_BIT:0]   hb_cnt_reg;

    // Anodes and segments are decoded from the current scan position and
    // registered together so a digit never shows its neighbour's pattern.
    always_comb begin
        an_next  = '1;
        seg_next = SEG_OFF;
        if (display_en_i) begin
            seg_next = hex_to_seg(nibbles[idx_reg]);
            if (presc_reg >= PRE_W'(BLANK_CYCLES)) begin
                an_next = ~(AN_ONE << idx_reg);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_reg    <= '0;
            presc_reg  <= '0;
            idx_reg    <= '0;
            an_reg     <= '1;
            seg_reg    <= SEG_OFF;
            hb_cnt_reg <= '0;
        end else begin
            led_reg    <= led_i;
            an_reg     <= an_next;
            seg_reg    <= seg_next;
            hb_cnt_reg <= hb_cnt_reg + 1'b1;
            if (presc_reg == PRE_W'(SCAN_CYCLES - 1)) begin
                presc_reg <= '0;
                if (idx_reg == IDX_W'(NUM_OF_ANODES - 1)) begin
                    idx_reg <= '0;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end else begin
                presc_reg <= presc_reg + 1'b1;
            end
        end
    end

    assign led_o     = led_reg;
    assign an        = an_reg;
    assign seg       = seg_reg;
    assign dp        = 1'b1;
    assign heartbeat = hb_cnt_reg[HEARTBEAT_BIT];

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl: table of scan vectors, hand sequences
// for debounce/enable/reset corners, and randomized traffic against a model.
module tb_board_io_ctrl;

    localparam int NA = 4;
    localparam int NS = 4;
    localparam int NL = 4;
    localparam int DB = 4;
    localparam int SC = 8;
    localparam int BL = 2;
    localparam int HB = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NS-1:0] sw_i = '0;
    logic [NS-1:0] sw_o;
    logic [NS-1:0] sw_rise_o;
    logic [NL-1:0] led_i = '0;
    logic [NL-1:0] led_o;
    logic [4*NA-1:0] display_i = '0;
    logic          display_en_i = 1'b0;
    logic [NA-1:0] an;
    logic [6:0]    seg;
    logic          dp;
    logic          heartbeat;

    int tests_run = 0;
    int tests_failed = 0;

    board_io_ctrl #(
        .NUM_OF_ANODES    (NA),
        .NUM_USED_SWITCHES(NS),
        .NUM_USED_LEDS    (NL),
        .DEBOUNCE_CYCLES  (DB),
        .SCAN_CYCLES      (SC),
        .BLANK_CYCLES     (BL),
        .HEARTBEAT_BIT    (HB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_i        (sw_i),
        .sw_o        (sw_o),
        .sw_rise_o   (sw_rise_o),
        .led_i       (led_i),
        .led_o       (led_o),
        .display_i   (display_i),
        .display_en_i(display_en_i),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .heartbeat   (heartbeat)
    );

    always #5 clk = ~clk;

    // Reference model state: edges since reset, debounced levels, raw samples per edge.
    int            k_m = 0;
    logic [NS-1:0] sw_m = '0;
    logic [NS-1:0] raw_h [DB+2];

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: record what the DUT samples, advance the model, compare every output.
    task automatic tick();
        logic          r;
        logic [NS-1:0] s;
        logic [NL-1:0] l;
        logic [4*NA-1:0] dsp;
        logic          e;
        logic [NS-1:0] exp_rise;
        logic [NL-1:0] exp_led;
        logic [NA-1:0] exp_an;
        logic [6:0]    exp_seg;
        logic          exp_hb;
        bit            flip;
        int            p;
        int            d;
        r = reset; s = sw_i; l = led_i; dsp = display_i; e = display_en_i;
        @(posedge clk);
        #1;
        exp_rise = '0;
        exp_an   = '1;
        exp_seg  = 7'h7F;
        if (r) begin
            k_m = 0;
            sw_m = '0;
            for (int i = 0; i < DB + 2; i++) raw_h[i] = '0;
            exp_led = '0;
            exp_hb  = 1'b0;
        end else begin
            k_m++;
            for (int i = DB + 1; i > 0; i--) raw_h[i] = raw_h[i-1];
            raw_h[0] = s;
            // A level that reached the debouncer on DB consecutive edges wins.
            for (int b = 0; b < NS; b++) begin
                flip = 1'b1;
                for (int j = 0; j < DB; j++)
                    if (raw_h[2+j][b] == sw_m[b]) flip = 1'b0;
                if (flip) begin
                    sw_m[b] = ~sw_m[b];
                    exp_rise[b] = sw_m[b];
                end
            end
            exp_led = l;
            exp_hb  = ((k_m / 8) % 2) == 1;
            p = (k_m - 1) % SC;
            d = ((k_m - 1) / SC) % NA;
            if (e) begin
                exp_seg = seg_of(dsp[4*d +: 4]);
                if (p >= BL) exp_an = ~(4'b0001 << d);
            end
        end
        chk("sw_o", 32'(sw_o), 32'(sw_m));
        chk("sw_rise_o", 32'(sw_rise_o), 32'(exp_rise));
        chk("led_o", 32'(led_o), 32'(exp_led));
        chk("an", 32'(an), 32'(exp_an));
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("dp", 32'(dp), 32'(1'b1));
        chk("heartbeat", 32'(heartbeat), 32'(exp_hb));
    endtask

    typedef struct {
        logic [3:0] led;
        logic [3:0] an;
        logic [6:0] seg;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int ncyc;
        // First two scan slots after reset with display 1234: digit 0 shows "4", digit 1 "3".
        tbl[0]  = '{4'h1, 4'hF, 7'h19};
        tbl[1]  = '{4'h2, 4'hF, 7'h19};
        tbl[2]  = '{4'h3, 4'hE, 7'h19};
        tbl[3]  = '{4'h4, 4'hE, 7'h19};
        tbl[4]  = '{4'h5, 4'hE, 7'h19};
        tbl[5]  = '{4'h6, 4'hE, 7'h19};
        tbl[6]  = '{4'h7, 4'hE, 7'h19};
        tbl[7]  = '{4'h8, 4'hE, 7'h19};
        tbl[8]  = '{4'h9, 4'hF, 7'h30};
        tbl[9]  = '{4'hA, 4'hF, 7'h30};
        tbl[10] = '{4'hB, 4'hD, 7'h30};
        tbl[11] = '{4'hC, 4'hD, 7'h30};
        tbl[12] = '{4'hD, 4'hD, 7'h30};
        tbl[13] = '{4'hE, 4'hD, 7'h30};
        tbl[14] = '{4'hF, 4'hD, 7'h30};
        tbl[15] = '{4'h0, 4'hD, 7'h30};
        for (int i = 0; i < DB + 2; i++) raw_h[i] = '0;

        reset = 1'b1;
        tick();
        tick();
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg), 32'h7F);
        $display("[TB] reset: an=%h seg=%h sw_o=%h led_o=%h", an, seg, sw_o, led_o);

        reset = 1'b0;
        display_i = 16'h1234;
        display_en_i = 1'b1;
        for (int r = 0; r < 16; r++) begin
            led_i = tbl[r].led;
            tick();
            chk("tbl_an", 32'(an), 32'(tbl[r].an));
            chk("tbl_seg", 32'(seg), 32'(tbl[r].seg));
            chk("tbl_led", 32'(led_o), 32'(tbl[r].led));
            $display("[TB] vec %0d: led_i=%h an=%b seg=%b", r, tbl[r].led, an, seg);
        end

        // Enable dropped in the middle of digit 2, then raised again.
        repeat (3) tick();
        display_en_i = 1'b0;
        tick();
        chk("en_off_an", 32'(an), 32'hF);
        chk("en_off_seg", 32'(seg), 32'h7F);
        tick();
        display_en_i = 1'b1;
        tick();
        chk("en_resume_an", 32'(an), 32'hB);
        $display("[TB] enable drop/resume: an=%b seg=%b", an, seg);

        // Clean 0->1 on switch 0 held.
        sw_i[0] = 1'b1;
        for (int t = 1; t <= 7; t++) begin
            tick();
            chk("deb_sw0", 32'(sw_o[0]), 32'(t >= 6));
            chk("deb_rise0", 32'(sw_rise_o[0]), 32'(t == 6));
        end
        $display("[TB] switch 0 debounce: sw_o=%b", sw_o);

        // Three-cycle glitch on switch 1 must be rejected.
        sw_i[1] = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            if (t == 4) sw_i[1] = 1'b0;
            tick();
            chk("glitch_sw1", 32'(sw_o[1]), 32'h0);
            chk("glitch_rise1", 32'(sw_rise_o[1]), 32'h0);
        end
        $display("[TB] switch 1 glitch: sw_o=%b", sw_o);

        // Reset two cycles into a debounce and mid-scan; timing restarts at release.
        sw_i[2] = 1'b1;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("rst_sw_o", 32'(sw_o), 32'h0);
        chk("rst_rise", 32'(sw_rise_o), 32'h0);
        chk("rst_led", 32'(led_o), 32'h0);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_hb", 32'(heartbeat), 32'h0);
        reset = 1'b0;
        for (int t = 1; t <= 17; t++) begin
            tick();
            if (t <= 8) chk("rst_deb_sw2", 32'(sw_o[2]), 32'(t >= 6));
            chk("rst_hb_blink", 32'(heartbeat), 32'(t >= 8 && t < 16));
        end
        $display("[TB] reset mid-activity: sw_o=%b heartbeat=%b", sw_o, heartbeat);

        // Randomized traffic checked only by the model.
        for (int n = 0; n < 60; n++) begin
            reset        = ($urandom_range(0, 15) == 0);
            sw_i         = sw_i ^ 4'($urandom_range(0, 15));
            led_i        = 4'($urandom);
            display_i    = 16'($urandom);
            display_en_i = ($urandom_range(0, 4) != 0);
            ncyc         = reset ? 1 : int'($urandom_range(1, 9));
            for (int c = 0; c < ncyc; c++) begin
                tick();
                reset = 1'b0;
            end
            $display("[TB] txn %0d: sw_i=%h led_i=%h disp=%h en=%b cycles=%0d sw_o=%h an=%b",
                     n, sw_i, led_i, display_i, display_en_i, ncyc, sw_o, an);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
